// File: rtl/regfile_mp.sv
// Multi-port register file with combinational reads, prioritised synchronous writes
// and a one-entry-per-cycle clear engine. Define REGFILE_MP_BYPASS_EN for write-through reads.
module regfile_mp #(
  parameter int unsigned N_ELEMENTS = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_READ     = 3,
  parameter int unsigned N_WRITE    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_READ*ADDR_WIDTH-1:0]     r_addr,
  output logic [N_READ*DATA_WIDTH-1:0]     r_data,
  input  logic [N_WRITE*ADDR_WIDTH-1:0]    w_addr,
  input  logic [N_WRITE*DATA_WIDTH-1:0]    w_data,
  input  logic [N_WRITE-1:0]               w_en,
  input  logic                             clr,
  output logic                             busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [N_ELEMENTS];
  logic [DATA_WIDTH-1:0]   mem_d [N_ELEMENTS];
  logic [N_WRITE-1:0]      w_hit;

  assign busy = (state_q == CLEAR);

  // A write port is live only when enabled and its address names a real entry.
  always_comb begin
    w_hit = '0;
    for (int unsigned j = 0; j < N_WRITE; j++) begin
      for (int unsigned i = 0; i < N_ELEMENTS; i++) begin
        if (w_en[j] && (w_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i))) begin
          w_hit[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        // Ascending port order makes the highest-index port win on a conflict.
        for (int unsigned i = 0; i < N_ELEMENTS; i++) begin
          for (int unsigned j = 0; j < N_WRITE; j++) begin
            if (w_en[j] && (w_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i))) begin
              mem_d[i] = w_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        for (int unsigned i = 0; i < N_ELEMENTS; i++) begin
          if (cnt_q == ADDR_WIDTH'(i)) begin
            mem_d[i] = '0;
          end
        end
        if (cnt_q == ADDR_WIDTH'(N_ELEMENTS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < N_ELEMENTS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    r_data = '0;
    for (int unsigned k = 0; k < N_READ; k++) begin
      for (int unsigned i = 0; i < N_ELEMENTS; i++) begin
        if (r_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i)) begin
          r_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
        end
      end
`ifdef REGFILE_MP_BYPASS_EN
      // Forward only in IDLE; writes presented during a sweep never land.
      if (state_q == IDLE) begin
        for (int unsigned j = 0; j < N_WRITE; j++) begin
          if (w_hit[j] && (w_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == r_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
            r_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table, clear sweep, reset mid-clear, bypass.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  r_addr = '0;
  logic [47:0] r_data;
  logic [5:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic [1:0]  w_en = '0;
  logic        clr = 1'b0;
  logic        busy;

  logic [8:0]  r_addr6 = '0;
  logic [47:0] r_data6;
  logic [5:0]  w_addr6 = '0;
  logic [31:0] w_data6 = '0;
  logic [1:0]  w_en6 = '0;
  logic        clr6 = 1'b0;
  logic        busy6;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(r_data), .w_addr(w_addr),
    .w_data(w_data), .w_en(w_en), .clr(clr), .busy(busy)
  );

  regfile_mp #(.N_ELEMENTS(6)) dut6 (
    .clk(clk), .rst(rst), .r_addr(r_addr6), .r_data(r_data6), .w_addr(w_addr6),
    .w_data(w_data6), .w_en(w_en6), .clr(clr6), .busy(busy6)
  );

  typedef struct {
    int          port;
    logic [15:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [1:0]  wen;
    logic [2:0]  wa0; logic [15:0] wd0;
    logic [2:0]  wa1; logic [15:0] wd1;
    logic [2:0]  ra0, ra1, ra2;
    logic [15:0] e0, e1, e2;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rd(input int k, input logic [2:0] a);
    r_addr[k*3 +: 3] = a;
  endtask

  task automatic set_wr(input int j, input logic [2:0] a, input logic [15:0] d);
    w_en[j] = 1'b1;
    w_addr[j*3 +: 3] = a;
    w_data[j*16 +: 16] = d;
  endtask

  task automatic expect_rd(input int k, input logic [15:0] e, input string nm);
    sb_t s;
    s.port = k; s.exp = e; s.name = nm;
    sb.push_back(s);
  endtask

  task automatic drain();
    sb_t s;
    #1;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      check(s.name, r_data[s.port*16 +: 16], s.exp);
    end
  endtask

  initial begin
    int busy_cycles;
    int guard;

    vecs[0] = '{2'b01, 3'd0, 16'h0101, 3'd0, 16'h0000, 3'd0, 3'd3, 3'd1, 16'h0101, 16'hBEEF, 16'h0000};
    vecs[1] = '{2'b11, 3'd5, 16'h1111, 3'd5, 16'h2222, 3'd5, 3'd0, 3'd3, 16'h2222, 16'h0101, 16'hBEEF};
    vecs[2] = '{2'b11, 3'd6, 16'h6666, 3'd7, 16'h7777, 3'd6, 3'd7, 3'd5, 16'h6666, 16'h7777, 16'h2222};
    vecs[3] = '{2'b10, 3'd4, 16'hDEAD, 3'd3, 16'h3333, 3'd3, 3'd4, 3'd6, 16'h3333, 16'h0000, 16'h6666};
    vecs[4] = '{2'b00, 3'd1, 16'hFFFF, 3'd1, 16'hFFFF, 3'd1, 3'd0, 3'd7, 16'h0000, 16'h0101, 16'h7777};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    set_rd(0, 3'd0); set_rd(1, 3'd3); set_rd(2, 3'd7);
    expect_rd(0, 16'h0000, "rst_a0"); expect_rd(1, 16'h0000, "rst_a3"); expect_rd(2, 16'h0000, "rst_a7");
    drain();
    check("rst_busy", {15'b0, busy}, 16'h0000);

    // Basic write/read
    set_wr(0, 3'd3, 16'hBEEF);
    tick();
    w_en = '0;
    for (int k = 0; k < 3; k++) begin
      set_rd(k, 3'd3);
      expect_rd(k, 16'hBEEF, "basic_a3");
    end
    drain();
    set_rd(1, 3'd2);
    expect_rd(1, 16'h0000, "basic_a2");
    drain();

    // Vector table: write, then read back the next cycle
    for (int v = 0; v < 5; v++) begin
      w_en = vecs[v].wen;
      w_addr = {vecs[v].wa1, vecs[v].wa0};
      w_data = {vecs[v].wd1, vecs[v].wd0};
      tick();
      w_en = '0;
      set_rd(0, vecs[v].ra0); set_rd(1, vecs[v].ra1); set_rd(2, vecs[v].ra2);
      expect_rd(0, vecs[v].e0, $sformatf("vec%0d_p0", v));
      expect_rd(1, vecs[v].e1, $sformatf("vec%0d_p1", v));
      expect_rd(2, vecs[v].e2, $sformatf("vec%0d_p2", v));
      drain();
    end

    // Out-of-range write on a 6-entry instance
    w_en6 = 2'b11;
    w_addr6 = {3'd7, 3'd5};
    w_data6 = {16'h7777, 16'h5555};
    tick();
    w_en6 = '0;
    r_addr6 = {3'd6, 3'd7, 3'd5};
    #1;
    check("n6_a5", r_data6[15:0], 16'h5555);
    check("n6_a7", r_data6[31:16], 16'h0000);
    check("n6_a6", r_data6[47:32], 16'h0000);
    for (int i = 0; i < 5; i++) begin
      r_addr6[2:0] = 3'(i);
      #1;
      check($sformatf("n6_keep%0d", i), r_data6[15:0], 16'h0000);
    end

    // Same-cycle read of a location being written
    set_wr(0, 3'd4, 16'h0007);
    tick();
    w_en = '0;
    set_wr(0, 3'd4, 16'h1234);
    set_rd(0, 3'd4);
`ifdef REGFILE_MP_BYPASS_EN
    expect_rd(0, 16'h1234, "bypass_same");
`else
    expect_rd(0, 16'h0007, "bypass_same");
`endif
    drain();
    tick();
    w_en = '0;
    expect_rd(0, 16'h1234, "bypass_next");
    drain();

    // Clear sweep: fill entries with i+1
    for (int i = 0; i < 8; i += 2) begin
      w_en = 2'b11;
      w_addr = {3'(i + 1), 3'(i)};
      w_data = {16'(i + 2), 16'(i + 1)};
      tick();
    end
    w_en = '0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_cycles = 0;
    #1;
    if (busy) busy_cycles++;
    set_rd(0, 3'd0); set_rd(1, 3'd7);
    expect_rd(0, 16'h0001, "clr0_a0"); expect_rd(1, 16'h0008, "clr0_a7");
    drain();
    set_wr(0, 3'd2, 16'hAAAA);
    clr = 1'b1;
    tick();
    w_en = '0;
    clr = 1'b0;
    #1;
    if (busy) busy_cycles++;
    set_rd(2, 3'd1);
    expect_rd(0, 16'h0000, "clr1_a0"); expect_rd(1, 16'h0008, "clr1_a7");
    expect_rd(2, 16'h0002, "clr1_a1");
    drain();
    set_wr(1, 3'd0, 16'h5A5A);
    guard = 0;
    while (busy && guard < 20) begin
      tick();
      w_en = '0;
      guard++;
      #1;
      if (busy) busy_cycles++;
    end
    check("busy_cycles", 16'(busy_cycles), 16'd8);
    for (int i = 0; i < 8; i++) begin
      set_rd(0, 3'(i));
      expect_rd(0, 16'h0000, $sformatf("swept_a%0d", i));
      drain();
    end
    tick();
    check("busy_after", {15'b0, busy}, 16'h0000);

    // Reset in the middle of a sweep
    set_wr(0, 3'd6, 16'h0606);
    set_wr(1, 3'd7, 16'h0707);
    tick();
    w_en = '0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick(); tick();
    check("mid_busy_pre", {15'b0, busy}, 16'h0001);
    #2 rst = 1'b1;
    #1;
    check("mid_busy", {15'b0, busy}, 16'h0000);
    set_rd(0, 3'd6); set_rd(1, 3'd7); set_rd(2, 3'd5);
    #1;
    check("mid_a6", r_data[15:0], 16'h0000);
    check("mid_a7", r_data[31:16], 16'h0000);
    check("mid_a5", r_data[47:32], 16'h0000);
    rst = 1'b0;
    set_wr(0, 3'd1, 16'h0111);
    tick();
    w_en = '0;
    set_rd(0, 3'd1);
    expect_rd(0, 16'h0111, "post_rst_wr");
    drain();
    check("post_rst_busy", {15'b0, busy}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the punc datapath: N_READ combinational read ports and N_WRITE synchronous write ports, with fixed write-port priority.
Adds a sequential clear engine that zeroes the array one entry per cycle and reports busy, so software/control can wipe state without asserting reset.
Sits between decode (read addresses) and writeback (write ports).

Parameters:
N_ELEMENTS, 8, number of entries; N_ELEMENTS <= 2**ADDR_WIDTH
ADDR_WIDTH, 3, address width in bits
DATA_WIDTH, 16, data width in bits
N_READ, 3, number of read ports (>=1)
N_WRITE, 2, number of write ports (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset; all entries -> 0, FSM -> IDLE
r_addr  input  N_READ*ADDR_WIDTH  read addresses, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
r_data  output  N_READ*DATA_WIDTH  read data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
w_addr  input  N_WRITE*ADDR_WIDTH  write addresses, packed as r_addr
w_data  input  N_WRITE*DATA_WIDTH  write data, packed as r_data
w_en  input  N_WRITE  per-port write enable
clr  input  1  clear request, sampled at rising edge
busy  output  1  high while clear sweep in progress (registered)

Behaviour:
- Reset (async, active-high): every entry = 0, state = IDLE, clear counter = 0, busy = 0, immediately and independent of clk.
- Reads: combinational, zero latency. r_data[k] = entry[r_addr[k]]. Address >= N_ELEMENTS -> returns 0.
- Writes (IDLE only): on rising edge, for each j with w_en[j]=1 and w_addr[j] < N_ELEMENTS, entry[w_addr[j]] <= w_data[j]. Visible on reads the following cycle.
- Write conflicts: multiple ports target the same address in the same cycle -> highest-index port wins. Out-of-range write addresses are ignored.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: clr=1 at an edge. The clear counter loads 0 and busy=1 from that edge on. Writes presented in that same cycle are still performed.
  - CLEAR: each edge, entry[cnt] <= 0 and cnt <= cnt+1. On the edge that clears entry N_ELEMENTS-1, go to IDLE and set busy=0.
  - busy is therefore high for exactly N_ELEMENTS cycles.
- In CLEAR:
  - All writes are dropped (no partial effect).
  - clr is ignored.
  - Reads return current contents: cleared entries read 0, not-yet-cleared entries keep their old value.
- Reset asserted mid-clear: immediate return to IDLE, busy=0, all entries 0.
- Counter width is ADDR_WIDTH bits; no wrap beyond N_ELEMENTS-1.

Optional Feature:
Macro REGFILE_MP_BYPASS_EN.
- Defined: write-through forwarding. In IDLE, if r_addr[k] matches an enabled, in-range write this cycle, r_data[k] = w_data of the winning (highest-index) matching port, combinationally. No forwarding in CLEAR, because those writes are dropped.
- Undefined: reads return stored contents only; a same-cycle write is visible the next cycle.

Test Plan:
- Reset: pulse rst asynchronously between edges -> all r_data = 0x0000 immediately; busy = 0.
- Basic write/read: port0 writes 0xBEEF to addr 3; next cycle all three read ports at addr 3 -> 0xBEEF; addr 2 -> 0x0000.
- Conflict: same cycle port0 writes addr 5 = 0x1111 and port1 writes addr 5 = 0x2222 -> addr 5 reads 0x2222. Port1 write to out-of-range addr (N_ELEMENTS=6, addr 7) -> no entry changes.
- Clear sweep: fill entries 0..7 with i+1, pulse clr 1 cycle:
  - busy high exactly 8 cycles.
  - After the 1st CLEAR edge, addr 0 reads 0 and addr 7 reads 8.
  - Write 0xAAAA to addr 2 during busy -> dropped; addr 2 reads 0 after the sweep.
  - A second clr pulse during busy -> ignored.
- Reset mid-clear: assert rst after 3 CLEAR edges -> busy falls without waiting for an edge; all entries 0; a write next cycle succeeds.
- Bypass: read addr 4 (holding 0x0007) while port0 writes 0x1234 to addr 4 -> same-cycle r_data = 0x1234 with REGFILE_MP_BYPASS_EN, 0x0007 without; both read 0x1234 next cycle.
